control_pipeline: RTL and testbench

//  Downstream consumer of the decode-stage control word from the main and ALU decoders.

---
 rtl/ctrl_pipe_pkg.sv | 60 ++++++
 rtl/control_pipeline_hazard_unit.sv | 69 ++++++
 rtl/control_pipeline.sv | 112 +++++++++++
 tb/tb_control_pipeline.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared types for the control pipeline: control-word layouts, stage bubbles and
// the register-match helper used by hazard detection and forwarding.
package ctrl_pipe_pkg;

    localparam int CTRL_REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RESULT_ALU = 2'b00,
        RESULT_MEM = 2'b01,
        RESULT_PC4 = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                       reg_write;
        result_src_t                result_src;
        logic                       mem_write;
        logic                       branch;
        logic                       jump;
        logic                       branch_neg;
        logic [2:0]                 alu_ctrl;
        logic                       alu_src;
        logic [CTRL_REG_ADDR_W-1:0] rs1;
        logic [CTRL_REG_ADDR_W-1:0] rs2;
        logic [CTRL_REG_ADDR_W-1:0] rd;
    } ctrl_word_t;

    // Later stages only carry the fields that are still consumed downstream.
    typedef struct packed {
        logic                       reg_write;
        result_src_t                result_src;
        logic                       mem_write;
        logic [CTRL_REG_ADDR_W-1:0] rd;
    } ex_mem_t;

    typedef struct packed {
        logic                       reg_write;
        result_src_t                result_src;
        logic [CTRL_REG_ADDR_W-1:0] rd;
    } mem_wb_t;

    localparam ctrl_word_t CTRL_BUBBLE   = '0;
    localparam ex_mem_t    EX_MEM_BUBBLE = '0;
    localparam mem_wb_t    MEM_WB_BUBBLE = '0;

    // A producer hits a source register only if it writes a non-x0 destination.
    function automatic logic reg_hit(
        input logic                       wr,
        input logic [CTRL_REG_ADDR_W-1:0] rd,
        input logic [CTRL_REG_ADDR_W-1:0] rs
    );
        return wr && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/control_pipeline_hazard_unit.sv
// Combinational hazard unit: load-use detection, stall/flush generation and EX
// forwarding selects. FORWARDING_EN enables forwarding; otherwise RAW hazards stall.
module hazard_unit
    import ctrl_pipe_pkg::*;
(
    input  logic                       reg_write_e,
    input  logic [1:0]                 result_src_e,
    input  logic [CTRL_REG_ADDR_W-1:0] rs1_d,
    input  logic [CTRL_REG_ADDR_W-1:0] rs2_d,
    input  logic [CTRL_REG_ADDR_W-1:0] rs1_e,
    input  logic [CTRL_REG_ADDR_W-1:0] rs2_e,
    input  logic [CTRL_REG_ADDR_W-1:0] rd_e,
    input  logic                       reg_write_m,
    input  logic [CTRL_REG_ADDR_W-1:0] rd_m,
    input  logic                       reg_write_w,
    input  logic [CTRL_REG_ADDR_W-1:0] rd_w,
    input  logic                       pc_src_e,
    output logic                       stall_f,
    output logic                       stall_d,
    output logic                       flush_d,
    output logic                       flush_e,
    output logic [1:0]                 forward_a_e,
    output logic [1:0]                 forward_b_e
);

    logic     lwstall;
    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;

`ifdef FORWARDING_EN
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = reg_write_e;
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{rs1_e, rs2_e, reg_write_w, rd_w};
`endif

    always_comb begin
        lwstall = (result_src_e == RESULT_MEM) && (rd_e != '0) &&
                  ((rd_e == rs1_d) || (rd_e == rs2_d));
        fwd_a   = FWD_RF;
        fwd_b   = FWD_RF;
`ifdef FORWARDING_EN
        // MEM holds the younger result, so it takes priority over WB.
        if (reg_hit(reg_write_m, rd_m, rs1_e)) begin
            fwd_a = FWD_MEM;
        end else if (reg_hit(reg_write_w, rd_w, rs1_e)) begin
            fwd_a = FWD_WB;
        end
        if (reg_hit(reg_write_m, rd_m, rs2_e)) begin
            fwd_b = FWD_MEM;
        end else if (reg_hit(reg_write_w, rd_w, rs2_e)) begin
            fwd_b = FWD_WB;
        end
`else
        lwstall = lwstall ||
                  reg_hit(reg_write_e, rd_e, rs1_d) || reg_hit(reg_write_e, rd_e, rs2_d) ||
                  reg_hit(reg_write_m, rd_m, rs1_d) || reg_hit(reg_write_m, rd_m, rs2_d);
`endif
        // A redirect discards the stalled instruction anyway, so the PC must not hold.
        stall_f     = lwstall && !pc_src_e;
        stall_d     = lwstall && !pc_src_e;
        flush_d     = pc_src_e;
        flush_e     = lwstall || pc_src_e;
        forward_a_e = fwd_a;
        forward_b_e = fwd_b;
    end

endmodule

// File: rtl/control_pipeline.sv
// Control-word pipeline (ID/EX, EX/MEM, MEM/WB) with EX branch resolution and hazard
// control. Define FORWARDING_EN to enable EX operand forwarding.
module control_pipeline
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = CTRL_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_write_d,
    input  logic [1:0]            result_src_d,
    input  logic                  mem_write_d,
    input  logic                  branch_d,
    input  logic                  jump_d,
    input  logic                  branch_neg_d,
    input  logic [2:0]            alu_ctrl_d,
    input  logic                  alu_src_d,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic                  zero_e,
    output logic [2:0]            alu_ctrl_e,
    output logic                  alu_src_e,
    output logic                  pc_src_e,
    output logic                  mem_write_m,
    output logic                  reg_write_w,
    output logic [1:0]            result_src_w,
    output logic [REG_ADDR_W-1:0] rd_w,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [1:0]            forward_a_e,
    output logic [1:0]            forward_b_e
);

    ctrl_word_t id_ex_d, id_ex_q;
    ex_mem_t    ex_mem_d, ex_mem_q;
    mem_wb_t    mem_wb_d, mem_wb_q;

    always_comb begin
        id_ex_d = CTRL_BUBBLE;
        if (!flush_e) begin
            id_ex_d.reg_write  = reg_write_d;
            id_ex_d.result_src = result_src_t'(result_src_d);
            id_ex_d.mem_write  = mem_write_d;
            id_ex_d.branch     = branch_d;
            id_ex_d.jump       = jump_d;
            id_ex_d.branch_neg = branch_neg_d;
            id_ex_d.alu_ctrl   = alu_ctrl_d;
            id_ex_d.alu_src    = alu_src_d;
            id_ex_d.rs1        = rs1_d;
            id_ex_d.rs2        = rs2_d;
            id_ex_d.rd         = rd_d;
        end

        ex_mem_d            = EX_MEM_BUBBLE;
        ex_mem_d.reg_write  = id_ex_q.reg_write;
        ex_mem_d.result_src = id_ex_q.result_src;
        ex_mem_d.mem_write  = id_ex_q.mem_write;
        ex_mem_d.rd         = id_ex_q.rd;

        mem_wb_d            = MEM_WB_BUBBLE;
        mem_wb_d.reg_write  = ex_mem_q.reg_write;
        mem_wb_d.result_src = ex_mem_q.result_src;
        mem_wb_d.rd         = ex_mem_q.rd;

        pc_src_e = id_ex_q.jump ||
                   (id_ex_q.branch && (id_ex_q.branch_neg ? zero_e : !zero_e));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q  <= CTRL_BUBBLE;
            ex_mem_q <= EX_MEM_BUBBLE;
            mem_wb_q <= MEM_WB_BUBBLE;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign alu_ctrl_e   = id_ex_q.alu_ctrl;
    assign alu_src_e    = id_ex_q.alu_src;
    assign mem_write_m  = ex_mem_q.mem_write;
    assign reg_write_w  = mem_wb_q.reg_write;
    assign result_src_w = mem_wb_q.result_src;
    assign rd_w         = mem_wb_q.rd;

    hazard_unit u_hazard (
        .reg_write_e  (id_ex_q.reg_write),
        .result_src_e (id_ex_q.result_src),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rs1_e        (id_ex_q.rs1),
        .rs2_e        (id_ex_q.rs2),
        .rd_e         (id_ex_q.rd),
        .reg_write_m  (ex_mem_q.reg_write),
        .rd_m         (ex_mem_q.rd),
        .reg_write_w  (mem_wb_q.reg_write),
        .rd_w         (mem_wb_q.rd),
        .pc_src_e     (pc_src_e),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .forward_a_e  (forward_a_e),
        .forward_b_e  (forward_b_e)
    );

endmodule

// File: tb/tb_control_pipeline.sv
// Directed self-checking bench for control_pipeline; expectations adapt to whether
// FORWARDING_EN is defined for the build.
module tb_control_pipeline;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       reg_write_d;
    logic [1:0] result_src_d;
    logic       mem_write_d;
    logic       branch_d;
    logic       jump_d;
    logic       branch_neg_d;
    logic [2:0] alu_ctrl_d;
    logic       alu_src_d;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [4:0] rd_d;
    logic       zero_e;
    logic [2:0] alu_ctrl_e;
    logic       alu_src_e;
    logic       pc_src_e;
    logic       mem_write_m;
    logic       reg_write_w;
    logic [1:0] result_src_w;
    logic [4:0] rd_w;
    logic       stall_f;
    logic       stall_d;
    logic       flush_d;
    logic       flush_e;
    logic [1:0] forward_a_e;
    logic [1:0] forward_b_e;

    int checks = 0;
    int errors = 0;

    control_pipeline dut (
        .clk          (clk),
        .rst          (rst),
        .reg_write_d  (reg_write_d),
        .result_src_d (result_src_d),
        .mem_write_d  (mem_write_d),
        .branch_d     (branch_d),
        .jump_d       (jump_d),
        .branch_neg_d (branch_neg_d),
        .alu_ctrl_d   (alu_ctrl_d),
        .alu_src_d    (alu_src_d),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rd_d         (rd_d),
        .zero_e       (zero_e),
        .alu_ctrl_e   (alu_ctrl_e),
        .alu_src_e    (alu_src_e),
        .pc_src_e     (pc_src_e),
        .mem_write_m  (mem_write_m),
        .reg_write_w  (reg_write_w),
        .result_src_w (result_src_w),
        .rd_w         (rd_w),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .forward_a_e  (forward_a_e),
        .forward_b_e  (forward_b_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the decode-stage control word, then let combinational outputs settle.
    task automatic applyStimulus(
        input logic       rw,
        input logic [1:0] rsrc,
        input logic       mw,
        input logic       br,
        input logic       jmp,
        input logic       bneg,
        input logic [2:0] alu,
        input logic       asrc,
        input logic [4:0] s1,
        input logic [4:0] s2,
        input logic [4:0] d
    );
        reg_write_d  = rw;
        result_src_d = rsrc;
        mem_write_d  = mw;
        branch_d     = br;
        jump_d       = jmp;
        branch_neg_d = bneg;
        alu_ctrl_d   = alu;
        alu_src_d    = asrc;
        rs1_d        = s1;
        rs2_d        = s2;
        rd_d         = d;
        #1;
    endtask

    task automatic applyNop();
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput(tag, {10'd0, alu_ctrl_e, alu_src_e, pc_src_e, mem_write_m, reg_write_w,
                          result_src_w, rd_w, stall_f, stall_d, flush_d, flush_e,
                          forward_a_e, forward_b_e}, 32'd0);
    endtask

    initial begin
        // Reset held two cycles with every decode input driven high.
        rst    = 1'b1;
        zero_e = 1'b1;
        applyStimulus(1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 1'b1, 5'd31, 5'd31, 5'd31);
        tick();
        checkAllZero("reset_cycle1");
        tick();
        checkAllZero("reset_cycle2");
        rst    = 1'b0;
        zero_e = 1'b0;
        applyNop();
        checkAllZero("post_reset_comb");
        tick();
        checkAllZero("post_reset_edge");

        // Load-use: lw x5 followed by add x6, x5, x0.
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 5'd0, 5'd0, 5'd5);
        tick();
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 5'd5, 5'd0, 5'd6);
        checkOutput("lu_stall_f", stall_f, 1);
        checkOutput("lu_stall_d", stall_d, 1);
        checkOutput("lu_flush_e", flush_e, 1);
        checkOutput("lu_flush_d", flush_d, 0);
        tick();
        checkOutput("lu_second_stall_f", stall_f, FWD ? 0 : 1);
        checkOutput("lu_second_flush_e", flush_e, FWD ? 0 : 1);
        tick();
        checkOutput("lu_wb_stall_f", stall_f, 0);
        checkOutput("lu_forward_a", forward_a_e, FWD ? 1 : 0);
        checkOutput("lu_wb_reg_write", reg_write_w, 1);
        checkOutput("lu_wb_rd", rd_w, 5);
        checkOutput("lu_wb_result_src", result_src_w, 1);
        checkOutput("lu_ex_alu", alu_ctrl_e, FWD ? 2 : 0);
        tick();
        checkOutput("lu_dep_ex_alu", alu_ctrl_e, 2);
        checkOutput("lu_dep_forward_a", forward_a_e, 0);
        applyNop();
        repeat (3) tick();

        // MEM and WB both write x3; the consumer reads x3 as rs2.
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3);
        tick();
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 5'd1, 5'd1, 5'd3);
        checkOutput("prio_i2_stall", stall_f, 0);
        tick();
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 5'd4, 5'd3, 5'd7);
        checkOutput("prio_i3_stall", stall_f, FWD ? 0 : 1);
        tick();
        checkOutput("prio_forward_b", forward_b_e, FWD ? 2 : 0);
        checkOutput("prio_forward_a", forward_a_e, 0);
        checkOutput("prio_stall_after", stall_f, FWD ? 0 : 1);
        applyNop();
        repeat (3) tick();

        // Same chain but the MEM-stage instruction is a store (no register write).
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3);
        tick();
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 5'd1, 5'd1, 5'd3);
        tick();
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 5'd4, 5'd3, 5'd7);
        checkOutput("wbfwd_i3_stall", stall_f, FWD ? 0 : 1);
        tick();
        checkOutput("wbfwd_forward_b", forward_b_e, FWD ? 1 : 0);
        checkOutput("wbfwd_mem_write", mem_write_m, 1);
        checkOutput("wbfwd_stall_after", stall_f, 0);
        applyNop();
        repeat (3) tick();

        // x0 as destination: no stall, no forward.
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 5'd0, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 5'd0, 5'd0, 5'd8);
        checkOutput("x0_stall_f", stall_f, 0);
        checkOutput("x0_flush_e", flush_e, 0);
        tick();
        checkOutput("x0_forward_a", forward_a_e, 0);
        checkOutput("x0_forward_b", forward_b_e, 0);
        checkOutput("x0_ex_alu", alu_ctrl_e, 3);
        applyNop();
        repeat (3) tick();

        // beq taken flushes; beq not taken; bne taken on !zero.
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 5'd1, 5'd2, 5'd0);
        tick();
        zero_e = 1'b1;
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 5'd0, 5'd0, 5'd9);
        checkOutput("beq_taken_pc_src", pc_src_e, 1);
        checkOutput("beq_taken_flush_d", flush_d, 1);
        checkOutput("beq_taken_flush_e", flush_e, 1);
        checkOutput("beq_taken_stall_f", stall_f, 0);
        tick();
        checkOutput("beq_bubble_alu", alu_ctrl_e, 0);
        checkOutput("beq_bubble_pc_src", pc_src_e, 0);
        checkOutput("beq_bubble_flush_e", flush_e, 0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 5'd1, 5'd2, 5'd0);
        tick();
        zero_e = 1'b0;
        #1;
        checkOutput("beq_not_taken_pc_src", pc_src_e, 0);
        checkOutput("beq_not_taken_flush_d", flush_d, 0);
        checkOutput("beq_not_taken_alu", alu_ctrl_e, 1);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 1'b0, 5'd1, 5'd2, 5'd0);
        tick();
        checkOutput("bne_taken_pc_src", pc_src_e, 1);
        checkOutput("bne_taken_flush_d", flush_d, 1);
        zero_e = 1'b1;
        #1;
        checkOutput("bne_not_taken_pc_src", pc_src_e, 0);
        zero_e = 1'b0;
        applyNop();
        repeat (3) tick();

        // Jump in EX coincident with a load-use hazard on D: flush wins, PC not held.
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd5);
        tick();
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 5'd5, 5'd0, 5'd6);
        checkOutput("jmp_lu_pc_src", pc_src_e, 1);
        checkOutput("jmp_lu_flush_d", flush_d, 1);
        checkOutput("jmp_lu_flush_e", flush_e, 1);
        checkOutput("jmp_lu_stall_f", stall_f, 0);
        checkOutput("jmp_lu_stall_d", stall_d, 0);
        tick();
        checkOutput("jmp_lu_bubble_alu", alu_ctrl_e, 0);
        applyNop();
        repeat (3) tick();

        // Fill the pipeline, then reset mid-operation.
        applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 5'd0, 5'd0, 5'd4);
        tick();
        checkOutput("fill_ex_alu", alu_ctrl_e, 5);
        checkOutput("fill_ex_alu_src", alu_src_e, 1);
        tick();
        checkOutput("fill_mem_write", mem_write_m, 1);
        tick();
        checkOutput("fill_wb_reg_write", reg_write_w, 1);
        checkOutput("fill_wb_rd", rd_w, 4);
        rst = 1'b1;
        tick();
        checkAllZero("mid_op_reset");
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
